load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; ports are named clk and rst_n.
REQ-002 The block SHALL have parameter ADDR_W, default 7, giving the word-address width of the data memory; the byte address is ADDR_W+2 bits.
REQ-003 The block SHALL have the following ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  CPU access request
- we  in  1  1 = store, 0 = load
- size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- sign_ext  in  1  sign-extend sub-word loads
- addr  in  ADDR_W+2  byte address
- wdata  in  32  store data, right-aligned
- ready  out  1  unit idle; request accepted when req=1
- done  out  1  one-cycle completion pulse
- misalign  out  1  valid with done; access rejected
- rdata  out  32  load result
- memread  out  1  memory read enable
- memwrite  out  1  memory write enable
- mem_address  out  ADDR_W  memory word address
- mem_writedata  out  32  memory write data
- mem_readdata  in  32  memory read data, combinational from mem_address

Function
REQ-004 The unit SHALL drive ready = 1 exactly when the FSM is in IDLE.
REQ-005 The unit SHALL accept a request on a rising edge where req=1 and ready=1, registering we, size, sign_ext, addr and wdata.
REQ-006 The unit SHALL ignore req while ready=0.
REQ-007 The FSM SHALL have the states IDLE, RD, WR, DONE and ERR.
REQ-008 On accept, the FSM SHALL transition as follows:
- misaligned or illegal access -> ERR
- load -> RD
- word store -> WR
- byte/half store -> RD (read-modify-write)
REQ-009 An access SHALL be misaligned when it is a half access with addr[0]=1, a word access with addr[1:0]!=0, or size=11.
REQ-010 RD SHALL last 1 cycle with memread=1; mem_readdata SHALL be captured at its closing edge; the next state SHALL be DONE for a load and WR for a store.
REQ-011 WR SHALL last 1 cycle with memwrite=1 and mem_address/mem_writedata stable for the whole cycle; the next state SHALL be DONE.
REQ-012 memread and memwrite SHALL never be 1 in the same cycle, and SHALL both be 0 in IDLE, DONE and ERR.
REQ-013 mem_address SHALL equal the registered addr[ADDR_W+1:2].
REQ-014 Byte lanes SHALL be little-endian: addr[1:0]=0 selects bits 7:0; a half access with addr[1]=1 selects bits 31:16.
REQ-015 A sub-word store SHALL write back the captured word with only the selected lane replaced by the low bits of wdata.
REQ-016 A sub-word load SHALL extract the selected lane, sign-extending it when sign_ext=1 and zero-extending it otherwise.
REQ-017 DONE SHALL last 1 cycle with done=1 and misalign=0; rdata SHALL be updated at entry to DONE for loads only; the next state SHALL be IDLE.
REQ-018 ERR SHALL last 1 cycle with done=1 and misalign=1, perform no memory access, leave rdata unchanged, and return to IDLE.
REQ-019 Latency from the accept edge to done SHALL be:
- load: 2 cycles
- word store: 2 cycles
- sub-word store: 3 cycles
- error: 1 cycle
REQ-020 rdata SHALL hold its value until the next successful load completes.

Reset
REQ-021 While rst_n=0, the FSM SHALL be in IDLE and done, misalign, memread, memwrite, rdata, mem_address and mem_writedata SHALL all be 0; ready SHALL read 1 but req SHALL be ignored.
REQ-022 Reset asserted mid-access SHALL force memread and memwrite to 0 immediately and abort the access without a done pulse; a write already begun in WR is not rolled back.

Configuration
REQ-023 With macro LSU_BYTE_LANE_EN defined, byte and half accesses SHALL be supported as specified above.
REQ-024 Without LSU_BYTE_LANE_EN, any size other than 10 SHALL be treated as misaligned (ERR path), and the RMW and lane logic SHALL be omitted.

Verification
Memory preloaded with mem[i] = i*10.
REQ-025 Word load, addr=0x014 -> memread high for exactly 1 cycle with mem_address=5; done 2 cycles after accept; rdata=50; memwrite never asserted.
REQ-026 Word store, addr=0x008, wdata=0xDEADBEEF -> one memwrite cycle with mem_address=2; a following load of 0x008 returns 0xDEADBEEF.
REQ-027 Byte store, addr=0x00D, wdata=0xAB -> RD then WR; mem[3] becomes 0x0000AB1E; done 3 cycles after accept. A following signed byte load of 0x00D returns 0xFFFFFFAB; an unsigned byte load returns 0x000000AB.
REQ-028 Word load, addr=0x006 -> done=1 and misalign=1 1 cycle after accept; no memread or memwrite; rdata unchanged.
REQ-029 rst_n pulled low during RD of a half store to 0x012 -> memread drops asynchronously; no done pulse; mem[4]=40 unchanged; ready=1 after release.
REQ-030 req held high through a load -> the second request is accepted only in IDLE after DONE; two done pulses separated by 3 cycles.

Source files
------------

// File: rtl/load_store_unit.sv
// ============================================================================
//  Module   : load_store_unit
//  Brief    : CPU load/store FSM in front of a single-cycle word memory, with
//             read-modify-write for sub-word stores (LSU_BYTE_LANE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W+1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              done,
   output logic              misalign,
   output logic [31:0]       rdata,
   output logic              memread,
   output logic              memwrite,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_writedata,
   input  logic [31:0]       mem_readdata
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_DONE = 3'd3,
      ST_ERR  = 3'd4
   } state_t;

   state_t            r_state;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_sign_ext;
   logic [ADDR_W+1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_done;
   logic              r_misalign;
   logic              r_memread;
   logic              r_memwrite;
   logic [31:0]       r_rdata;
   logic [31:0]       r_mem_writedata;

   logic              w_misalign;
   logic [31:0]       w_load_val;
   logic [31:0]       w_store_val;

`ifdef LSU_BYTE_LANE_EN
   logic [7:0]        w_byte;
   logic [15:0]       w_half;

   assign w_misalign = (size == 2'b11)
                    || ((size == 2'b01) && addr[0])
                    || ((size == 2'b10) && (addr[1:0] != 2'b00));

   // Lane extraction/merge operate on the word read during RD.
   always_comb begin
      w_byte      = mem_readdata[{r_addr[1:0], 3'b000} +: 8];
      w_half      = mem_readdata[{r_addr[1], 4'b0000} +: 16];
      w_load_val  = mem_readdata;
      w_store_val = mem_readdata;
      case (r_size)
         2'b00: begin
            w_load_val = {{24{r_sign_ext & w_byte[7]}}, w_byte};
            w_store_val[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
         end
         2'b01: begin
            w_load_val = {{16{r_sign_ext & w_half[15]}}, w_half};
            w_store_val[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
         end
         default: w_store_val = r_wdata;
      endcase
   end
`else
   logic w_unused;

   assign w_misalign  = (size != 2'b10) || (addr[1:0] != 2'b00);
   assign w_load_val  = mem_readdata;
   assign w_store_val = r_wdata;
   assign w_unused    = &{1'b0, r_size, r_sign_ext, r_addr[1:0]};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_we            <= 1'b0;
         r_size          <= 2'b00;
         r_sign_ext      <= 1'b0;
         r_addr          <= '0;
         r_wdata         <= 32'd0;
         r_done          <= 1'b0;
         r_misalign      <= 1'b0;
         r_memread       <= 1'b0;
         r_memwrite      <= 1'b0;
         r_rdata         <= 32'd0;
         r_mem_writedata <= 32'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_we       <= we;
                  r_size     <= size;
                  r_sign_ext <= sign_ext;
                  r_addr     <= addr;
                  r_wdata    <= wdata;
                  if (w_misalign) begin
                     r_state    <= ST_ERR;
                     r_done     <= 1'b1;
                     r_misalign <= 1'b1;
                  end else if (we && (size == 2'b10)) begin
                     r_state         <= ST_WR;
                     r_memwrite      <= 1'b1;
                     r_mem_writedata <= wdata;
                  end else begin
                     // Loads and sub-word stores both start with a read.
                     r_state   <= ST_RD;
                     r_memread <= 1'b1;
                  end
               end
            end
            ST_RD: begin
               r_memread <= 1'b0;
               if (r_we) begin
                  r_state         <= ST_WR;
                  r_memwrite      <= 1'b1;
                  r_mem_writedata <= w_store_val;
               end else begin
                  r_state <= ST_DONE;
                  r_done  <= 1'b1;
                  r_rdata <= w_load_val;
               end
            end
            ST_WR: begin
               r_memwrite <= 1'b0;
               r_state    <= ST_DONE;
               r_done     <= 1'b1;
            end
            ST_DONE, ST_ERR: begin
               r_state    <= ST_IDLE;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
            end
            default: begin
               r_state    <= ST_IDLE;
               r_done     <= 1'b0;
               r_misalign <= 1'b0;
               r_memread  <= 1'b0;
               r_memwrite <= 1'b0;
            end
         endcase
      end
   end

   assign ready         = (r_state == ST_IDLE);
   assign done          = r_done;
   assign misalign      = r_misalign;
   assign rdata         = r_rdata;
   assign memread       = r_memread;
   assign memwrite      = r_memwrite;
   assign mem_address   = r_addr[ADDR_W+1:2];
   assign mem_writedata = r_mem_writedata;

endmodule

`default_nettype wire
